bit_run_encoder: RTL and testbench

//  Downstream consumer of the per-row bit serializer. Compresses the serial bit stream
//  (bit, index, valid) into run-length records of the form {value, start, length, last}.

---
 rtl/bre_pkg.sv | 22 ++
 rtl/bit_run_encoder_if.sv | 25 ++
 rtl/bre_fifo.sv | 50 +++++
 rtl/bit_run_encoder.sv | 185 ++++++++++++++++++
 tb/tb_bit_run_encoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bre_pkg.sv
// Shared types for the bit run encoder.
// Row geometry, run record layout and FSM states.
package bre_pkg;

  localparam int ROW_WIDTH  = 1280;
  localparam int IDX_W      = 11;
  localparam int LEN_W      = 11;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic             value;
    logic [IDX_W-1:0] start;
    logic [LEN_W-1:0] length;
    logic             last;
  } run_rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bre_state_e;

endpackage

// File: rtl/bit_run_encoder_if.sv
// Run-record output bus with valid/ready handshake.
// master = record producer, slave = consumer.
interface bit_run_encoder_if;
  import bre_pkg::*;

  logic             run_value;
  logic [IDX_W-1:0] run_start;
  logic [LEN_W-1:0] run_length;
  logic             run_last;
  logic             run_valid;
  logic             run_ready;

  modport master (
    output run_value, run_start, run_length,
    output run_last, run_valid,
    input  run_ready
  );

  modport slave (
    input  run_value, run_start, run_length,
    input  run_last, run_valid,
    output run_ready
  );

endinterface

// File: rtl/bre_fifo.sv
// First-word fall-through FIFO of run records.
// Head data reads as zero while empty.
module bre_fifo
  import bre_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wr_en_i,
  input  run_rec_t wr_data_i,
  input  logic     rd_en_i,
  output run_rec_t rd_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  run_rec_t        mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            do_wr;
  logic            do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; extra MSB separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/bit_run_encoder.sv
// Run-length encoder for the serial row bit stream.
// Optional: BRE_ONES_ONLY_EN suppresses non-final zero runs.
module bit_run_encoder
  import bre_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic [IDX_W-1:0] bit_index,
  input  logic             bit_valid,
  bit_run_encoder_if.master run_if,
  output logic             overflow,
  output logic             sync_err
);

  bre_state_e       state_q, state_d;
  logic             val_q, val_d;
  logic [IDX_W-1:0] start_q, start_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pend_vld_q, pend_vld_d;
  run_rec_t         pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             sync_q, sync_d;

  run_rec_t rec_a, rec_b, n1, n2, wr_rec, head;
  logic     a_vld, b_vld, a_keep, b_keep;
  logic     n1_vld, n2_vld, sync_set;
  logic     wr_en, drop, fifo_drop;
  logic     full, empty, pop;
  logic     row_end, is_zero, same, mid;

  assign row_end = (bit_index == IDX_W'(ROW_WIDTH - 1));
  assign is_zero = (bit_index == '0);
  assign same    = (bit_in == val_q);
  assign mid     = !is_zero && !row_end;

  // Run tracking: decide which records close on this bit.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    start_d  = start_q;
    len_d    = len_q;
    rec_a    = '0;
    rec_b    = '0;
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    sync_set = 1'b0;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (row_end) begin
            rec_a = '{bit_in, bit_index, LEN_W'(1), 1'b1};
            a_vld = 1'b1;
          end else begin
            val_d   = bit_in;
            start_d = bit_index;
            len_d   = LEN_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            is_zero: begin
              rec_a    = '{val_q, start_q, len_q, 1'b1};
              a_vld    = 1'b1;
              sync_set = 1'b1;
              val_d    = bit_in;
              start_d  = bit_index;
              len_d    = LEN_W'(1);
            end
            row_end && same: begin
              rec_a   = '{val_q, start_q,
                          len_q + LEN_W'(1), 1'b1};
              a_vld   = 1'b1;
              state_d = IDLE;
            end
            row_end && !same: begin
              rec_a   = '{val_q, start_q, len_q, 1'b0};
              a_vld   = 1'b1;
              rec_b   = '{bit_in, bit_index,
                          LEN_W'(1), 1'b1};
              b_vld   = 1'b1;
              state_d = IDLE;
            end
            mid && same: begin
              len_d = len_q + LEN_W'(1);
            end
            mid && !same: begin
              rec_a   = '{val_q, start_q, len_q, 1'b0};
              a_vld   = 1'b1;
              val_d   = bit_in;
              start_d = bit_index;
              len_d   = LEN_W'(1);
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BRE_ONES_ONLY_EN
  assign a_keep = a_vld && (rec_a.value || rec_a.last);
  assign b_keep = b_vld && (rec_b.value || rec_b.last);
`else
  assign a_keep = a_vld;
  assign b_keep = b_vld;
`endif

  assign n1     = a_keep ? rec_a : rec_b;
  assign n1_vld = a_keep || b_keep;
  assign n2     = rec_b;
  assign n2_vld = a_keep && b_keep;

  // Write arbitration: pending first, spill one, drop the rest.
  always_comb begin
    wr_en      = 1'b0;
    wr_rec     = '0;
    pend_vld_d = 1'b0;
    pend_d     = pend_q;
    drop       = 1'b0;
    if (pend_vld_q) begin
      wr_en      = 1'b1;
      wr_rec     = pend_q;
      pend_vld_d = n1_vld;
      pend_d     = n1;
      drop       = n2_vld;
    end else begin
      wr_en      = n1_vld;
      wr_rec     = n1;
      pend_vld_d = n2_vld;
      pend_d     = n2;
    end
  end

  assign pop       = run_if.run_ready;
  assign fifo_drop = wr_en && full && !(pop && !empty);
  assign ovf_d     = ovf_q | drop | fifo_drop;
  assign sync_d    = sync_q | sync_set;

  // State, open run, pending slot and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      val_q      <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      start_q    <= start_d;
      len_q      <= len_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      sync_q     <= sync_d;
    end
  end

  bre_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_rec),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign run_if.run_value  = head.value;
  assign run_if.run_start  = head.start;
  assign run_if.run_length = head.length;
  assign run_if.run_last   = head.last;
  assign run_if.run_valid  = !empty;
  assign overflow          = ovf_q;
  assign sync_err          = sync_q;

endmodule

// File: tb/tb_bit_run_encoder.sv
// Scoreboard bench for bit_run_encoder.
// Reference model builds runs from buffered bit segments.
module tb_bit_run_encoder;
  import bre_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             bit_in;
  logic [IDX_W-1:0] bit_index;
  logic             bit_valid;
  logic             overflow;
  logic             sync_err;

  bit_run_encoder_if rif ();

  bit_run_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_index (bit_index),
    .bit_valid (bit_valid),
    .run_if    (rif),
    .overflow  (overflow),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  run_rec_t sb [$];
  int       seg [$];
  bit       seg_val;
  bit       push_en = 1'b1;
  bit       rand_rdy = 1'b0;
  bit       rand_gap = 1'b0;
  bit       exp_sync = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rec(run_rec_t got, run_rec_t exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL record: got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d}",
               got.value, got.start, got.length, got.last,
               exp.value, exp.start, exp.length, exp.last);
    end
  endtask

  function automatic void emit(bit v, int st, int len, bit lst);
    run_rec_t r;
`ifdef BRE_ONES_ONLY_EN
    if (!v && !lst) return;
`endif
    r.value  = v;
    r.start  = IDX_W'(st);
    r.length = LEN_W'(len);
    r.last   = lst;
    if (push_en) sb.push_back(r);
  endfunction

  // A run is a maximal segment of equal bits, cut at row end and on resync.
  function automatic void model_step(bit b, int idx);
    if (seg.size() > 0 && idx == 0) begin
      emit(seg_val, seg[0], seg.size(), 1'b1);
      exp_sync = 1'b1;
      seg.delete();
    end else if (seg.size() > 0 && b != seg_val) begin
      emit(seg_val, seg[0], seg.size(), 1'b0);
      seg.delete();
    end
    if (seg.size() == 0) seg_val = b;
    seg.push_back(idx);
    if (idx == ROW_WIDTH - 1) begin
      emit(seg_val, seg[0], seg.size(), 1'b1);
      seg.delete();
    end
  endfunction

  task automatic monitor();
    run_rec_t got;
    forever begin
      @(negedge clk);
      if (!reset && rif.run_valid && rif.run_ready) begin
        got.value  = rif.run_value;
        got.start  = rif.run_start;
        got.length = rif.run_length;
        got.last   = rif.run_last;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected record: got {%0d,%0d,%0d,%0d} expected none",
                   got.value, got.start, got.length, got.last);
        end else begin
          check_rec(got, sb.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rif.run_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(bit b, int idx);
    if (rand_gap)
      while ($urandom_range(2) == 0) tick();
    bit_in    = b;
    bit_index = IDX_W'(idx);
    bit_valid = 1'b1;
    model_step(b, idx);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 4000; i++) begin
      if (sb.size() == 0 && !rif.run_valid) break;
      tick();
    end
    repeat (3) tick();
    check(name, sb.size(), 0);
  endtask

  task automatic rand_row(int last_idx);
    bit b = 1'($urandom_range(1));
    for (int i = 0; i <= last_idx; i++) begin
      if ($urandom_range(3) == 0) b = ~b;
      send(b, i);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bit_in        = 1'b0;
    bit_index     = '0;
    bit_valid     = 1'b0;
    rif.run_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(rif.run_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_sync_err", int'(sync_err), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < ROW_WIDTH; i++) send(1'b0, i);
    drain("t1_zeros");

    for (int i = 0; i < ROW_WIDTH; i++) send(i < 10, i);
    drain("t2_ones_then_zeros");

    for (int i = 0; i < ROW_WIDTH; i++)
      send(i == ROW_WIDTH - 1, i);
    drain("t3_last_bit_flip");
    check("t3_overflow", int'(overflow), 0);

    rif.run_ready = 1'b0;
    push_en = 1'b0;
    for (int i = 0; i < 20; i++) send(1'(i & 1), i);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      run_rec_t r;
      r.value  = 1'(i & 1);
      r.start  = IDX_W'(i);
      r.length = LEN_W'(1);
      r.last   = 1'b0;
      sb.push_back(r);
    end
    push_en = 1'b1;
    repeat (3) tick();
    check("t4_overflow", int'(overflow), 1);
    check("t4_held", int'(rif.run_valid), 1);
    rif.run_ready = 1'b1;
    drain("t4_drain");

    for (int i = 20; i <= 500; i++) send(1'b1, i);
    reset = 1'b1;
    #1;
    check("t5_reset_valid", int'(rif.run_valid), 0);
    check("t5_reset_overflow", int'(overflow), 0);
    sb.delete();
    seg.delete();
    exp_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < ROW_WIDTH; i++) send(1'b1, i);
    drain("t5_full_ones");
    check("t5_sync_err", int'(sync_err), 0);

    for (int i = 0; i <= 700; i++) send(1'b1, i % 701 == 700 ? 0 : i);
    check("t6_sync_err", int'(sync_err), 1);
    for (int i = 1; i < ROW_WIDTH; i++) send(1'b1, i);
    drain("t6_resync");

    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    rand_row(ROW_WIDTH - 1);
    rand_row(599);
    rand_row(ROW_WIDTH - 1);
    rand_row(ROW_WIDTH - 1);
    rand_rdy = 1'b0;
    rif.run_ready = 1'b1;
    drain("rand_drain");
    check("rand_sync_err", int'(sync_err), int'(exp_sync));
    check("rand_overflow", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
